// File: rtl/pacman_inputs.sv
// pacman_inputs: conditions PS/2 keys and joysticks into the Pac-Man active-low in0/in1 buses.
// Define PACMAN_INPUTS_JPAC_EN to also decode the JPAC/IPAC key codes (coin1, P2 keys, alt starts).
module pacman_inputs #(
   parameter int unsigned COIN_W   = 2400000,
   parameter int unsigned COIN_GAP = 2400000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [10:0] ps2_key,
   input  logic [15:0] joystick_0,
   input  logic [15:0] joystick_1,
   input  logic        rotate,
   input  logic        rack_test,
   output logic [7:0]  in0,
   output logic [7:0]  in1
);
   localparam int K_UP1 = 0, K_DN1 = 1, K_LF1 = 2, K_RT1 = 3;
   localparam int K_UP2 = 4, K_DN2 = 5, K_LF2 = 6, K_RT2 = 7;
   localparam int K_ST1 = 8, K_ST2 = 9, K_COIN1 = 10, K_COIN2 = 11, K_SKIP = 12;
   localparam logic [31:0] COIN_LOAD = 32'(COIN_W - 1);
   localparam logic [31:0] GAP_LOAD  = 32'(COIN_GAP - 1);

   typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP} coin_t;

   logic            old_tog_q, ev_q;
   logic [9:0]      key_q;
   logic [12:0]     keys_q, keys_d;
   logic [1:0][3:0] raw, s1_q, s2_q, mask_q, mask_d, dir;
   logic [3:0]      pass_raw, pt1_q, pt2_q;
   logic [1:0]      coin_src, cs1_q, cs2_q;
   coin_t           coin_q [2];
   coin_t           coin_d [2];
   logic [31:0]     cnt_q [2];
   logic [31:0]     cnt_d [2];
   logic [7:0]      in0_q, in0_d, in1_q, in1_d;
   logic            unused_ok;

   // Direction vectors are {up, down, left, right}.
   function automatic logic [3:0] rot4(input logic [3:0] v, input logic en);
      return en ? {v[1], v[0], v[2], v[3]} : v;
   endfunction

   function automatic logic [3:0] steer(input logic [3:0] rise, input logic [3:0] cur);
      if (rise[3])      return 4'b1000;
      else if (rise[2]) return 4'b0100;
      else if (rise[1]) return 4'b0010;
      else if (rise[0]) return 4'b0001;
      return cur;
   endfunction

   always_comb begin
      keys_d = keys_q;
      if (ev_q) begin
         case (key_q[7:0])
            8'h75: keys_d[K_UP1] = key_q[9];
            8'h72: keys_d[K_DN1] = key_q[9];
            8'h6B: keys_d[K_LF1] = key_q[9];
            8'h74: keys_d[K_RT1] = key_q[9];
            8'h05: if (!key_q[8]) keys_d[K_ST1]   = key_q[9];
            8'h06: if (!key_q[8]) keys_d[K_ST2]   = key_q[9];
            8'h04: if (!key_q[8]) keys_d[K_COIN2] = key_q[9];
            8'h03: if (!key_q[8]) keys_d[K_SKIP]  = key_q[9];
`ifdef PACMAN_INPUTS_JPAC_EN
            8'h16: if (!key_q[8]) keys_d[K_ST1]   = key_q[9];
            8'h1E: if (!key_q[8]) keys_d[K_ST2]   = key_q[9];
            8'h2E: if (!key_q[8]) keys_d[K_COIN1] = key_q[9];
            8'h36: if (!key_q[8]) keys_d[K_COIN2] = key_q[9];
            8'h2D: if (!key_q[8]) keys_d[K_UP2]   = key_q[9];
            8'h2B: if (!key_q[8]) keys_d[K_DN2]   = key_q[9];
            8'h23: if (!key_q[8]) keys_d[K_LF2]   = key_q[9];
            8'h34: if (!key_q[8]) keys_d[K_RT2]   = key_q[9];
`endif
            default: ;
         endcase
      end
   end

   // Without JPAC decoding the P2/coin1 latches simply never set.
   assign raw[0] = rot4({keys_q[K_UP1] | joystick_0[3], keys_q[K_DN1] | joystick_0[2],
                         keys_q[K_LF1] | joystick_0[1], keys_q[K_RT1] | joystick_0[0]}, rotate);
   assign raw[1] = rot4({keys_q[K_UP2] | joystick_1[3], keys_q[K_DN2] | joystick_1[2],
                         keys_q[K_LF2] | joystick_1[1], keys_q[K_RT2] | joystick_1[0]}, rotate);
   assign pass_raw = {rack_test, keys_q[K_ST2] | joystick_0[6] | joystick_1[6],
                      keys_q[K_ST1] | joystick_0[5] | joystick_1[5], keys_q[K_SKIP]};
   assign coin_src  = {keys_q[K_COIN2], keys_q[K_COIN1]};
   assign unused_ok = ^{joystick_0[15:7], joystick_0[4], joystick_1[15:7], joystick_1[4]};

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         mask_d[p] = steer(s1_q[p] & ~s2_q[p], mask_q[p]);
         dir[p]    = s1_q[p] & mask_q[p];
      end
   end

   always_comb begin
      for (int c = 0; c < 2; c++) begin
         coin_d[c] = coin_q[c];
         cnt_d[c]  = cnt_q[c];
         case (coin_q[c])
            C_IDLE:
               if (cs1_q[c] && !cs2_q[c]) begin
                  coin_d[c] = C_PULSE;
                  cnt_d[c]  = COIN_LOAD;
               end
            C_PULSE:
               if (cnt_q[c] == '0) begin
                  coin_d[c] = C_GAP;
                  cnt_d[c]  = GAP_LOAD;
               end else begin
                  cnt_d[c] = cnt_q[c] - 32'd1;
               end
            C_GAP:
               if (cnt_q[c] == '0) coin_d[c] = C_IDLE;
               else                cnt_d[c]  = cnt_q[c] - 32'd1;
            default: coin_d[c] = C_IDLE;
         endcase
      end
   end

   always_comb begin
      in0_d = ~{1'b0, pt2_q[0], coin_q[0] == C_PULSE, coin_q[1] == C_PULSE,
                dir[0][2], dir[0][0], dir[0][1], dir[0][3]};
      in1_d = ~{pt2_q[3], pt2_q[2], pt2_q[1], 1'b0,
                dir[1][2], dir[1][0], dir[1][1], dir[1][3]};
   end

   always_ff @(posedge clk_sys) begin
      for (int c = 0; c < 2; c++) cnt_q[c] <= cnt_d[c];
      if (reset) begin
         coin_q[0] <= C_IDLE;
         coin_q[1] <= C_IDLE;
      end else begin
         coin_q[0] <= coin_d[0];
         coin_q[1] <= coin_d[1];
      end
   end

   // The event is registered, so latches update one edge after the toggle is sampled.
   always_ff @(posedge clk_sys) begin
      key_q     <= ps2_key[9:0];
      old_tog_q <= ps2_key[10];
      if (reset) begin
         ev_q   <= 1'b0;
         keys_q <= '0;
         s1_q   <= '0;
         s2_q   <= '0;
         mask_q <= '0;
         pt1_q  <= '0;
         pt2_q  <= '0;
         cs1_q  <= '0;
         cs2_q  <= '0;
         in0_q  <= 8'hFF;
         in1_q  <= 8'hFF;
      end else begin
         ev_q   <= ps2_key[10] ^ old_tog_q;
         keys_q <= keys_d;
         s1_q   <= raw;
         s2_q   <= s1_q;
         mask_q <= mask_d;
         pt1_q  <= pass_raw;
         pt2_q  <= pt1_q;
         cs1_q  <= coin_src;
         cs2_q  <= cs1_q;
         in0_q  <= in0_d;
         in1_q  <= in1_d;
      end
   end

   assign in0 = in0_q;
   assign in1 = in1_q;
endmodule

// File: tb/tb_pacman_inputs.sv
// Directed scoreboard bench for pacman_inputs with COIN_W=8, COIN_GAP=4.
module tb_pacman_inputs;
   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic [15:0] joystick_0, joystick_1;
   logic        rotate, rack_test;
   logic [7:0]  in0, in1;
   logic        tog;
   int          cyc = 0;
   int          nchk = 0, npass = 0, nfail = 0;

   int          due_q[$];
   logic [15:0] exp_q[$];
   string       tag_q[$];

   pacman_inputs #(.COIN_W(8), .COIN_GAP(4)) dut (
      .clk_sys(clk), .reset(reset), .ps2_key(ps2_key),
      .joystick_0(joystick_0), .joystick_1(joystick_1),
      .rotate(rotate), .rack_test(rack_test), .in0(in0), .in1(in1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: compare every expectation whose due cycle has arrived.
   always @(negedge clk) begin
      for (int i = due_q.size() - 1; i >= 0; i--) begin
         if (due_q[i] <= cyc) begin
            nchk++;
            assert (due_q[i] == cyc && {in0, in1} === exp_q[i]) npass++;
            else begin
               nfail++;
               $error("FAIL %s cyc=%0d in0/in1=%h expected %h", tag_q[i], cyc, {in0, in1}, exp_q[i]);
            end
            due_q.delete(i);
            exp_q.delete(i);
            tag_q.delete(i);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_at(input int off, input logic [7:0] e0, input logic [7:0] e1, input string tag);
      due_q.push_back(cyc + off);
      exp_q.push_back({e0, e1});
      tag_q.push_back(tag);
   endtask

   task automatic key(input logic pr, input logic ext, input logic [7:0] code);
      tog     = ~tog;
      ps2_key = {tog, pr, ext, code};
   endtask

   task automatic coin_window(input int first, input int last, input logic [7:0] low, input string tag);
      for (int k = first; k <= last; k++)
         exp_at(k, (k >= 5 && k <= 12) ? low : 8'hFF, 8'hFF, tag);
   endtask

   initial begin
      reset = 1'b1; tog = 1'b1; ps2_key = 11'h400;
      joystick_0 = '0; joystick_1 = '0; rotate = 1'b0; rack_test = 1'b0;
      tick(3);
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) exp_at(k, 8'hFF, 8'hFF, "idle_after_reset");
      tick(21);

      key(1'b1, 1'b1, 8'h75);
      exp_at(4, 8'hFF, 8'hFF, "key_up_early");
      exp_at(5, 8'hFE, 8'hFF, "key_up");
      tick(8);
      key(1'b0, 1'b1, 8'h75);
      exp_at(3, 8'hFE, 8'hFF, "key_up_held");
      exp_at(5, 8'hFF, 8'hFF, "key_up_release");
      tick(8);

      joystick_0 = 16'h0008;
      exp_at(3, 8'hFE, 8'hFF, "joy_up");
      tick(3);
      joystick_0 = 16'h000A;
      exp_at(2, 8'hFE, 8'hFF, "steer_up_still");
      exp_at(3, 8'hFD, 8'hFF, "steer_left_wins");
      tick(3);
      joystick_0 = 16'h0008;
      exp_at(1, 8'hFD, 8'hFF, "steer_left_held");
      exp_at(2, 8'hFF, 8'hFF, "steer_up_suppressed");
      tick(4);
      joystick_0 = 16'h0000;
      tick(4);

      rotate = 1'b1; joystick_1 = 16'h0002;
      exp_at(2, 8'hFF, 8'hFF, "rot_p2_early");
      exp_at(3, 8'hFF, 8'hFE, "rot_p2_left_to_up");
      tick(4);
      joystick_1 = 16'h0000;
      joystick_0 = 16'h000C;
      exp_at(3, 8'hFD, 8'hFF, "rot_p1_updown_to_left");
      tick(4);
      joystick_0 = 16'h0000; rotate = 1'b0;
      tick(4);
      joystick_0 = 16'h000C;
      exp_at(2, 8'hFF, 8'hFF, "simul_early");
      exp_at(3, 8'hFE, 8'hFF, "simul_up_wins");
      tick(4);
      joystick_0 = 16'h0000;
      tick(4);

      rack_test = 1'b1;
      exp_at(2, 8'hFF, 8'hFF, "rack_early");
      exp_at(3, 8'hFF, 8'h7F, "rack_test");
      tick(4);
      rack_test = 1'b0; joystick_1 = 16'h0040;
      exp_at(3, 8'hFF, 8'hBF, "joy_start2");
      tick(4);
      joystick_1 = 16'h0000;
      tick(4);

      key(1'b1, 1'b1, 8'h05);
      exp_at(5, 8'hFF, 8'hFF, "ext_f1_ignored");
      exp_at(7, 8'hFF, 8'hFF, "ext_f1_ignored_late");
      tick(8);

      key(1'b1, 1'b0, 8'h75);
      exp_at(5, 8'hFE, 8'hFF, "consec_up");
      exp_at(6, 8'hFE, 8'hDF, "consec_f1");
      tick(1);
      key(1'b1, 1'b0, 8'h05);
      exp_at(4, 8'hFE, 8'hFF, "consec_f1_early");
      tick(8);
      key(1'b0, 1'b0, 8'h75);
      tick(1);
      key(1'b0, 1'b0, 8'h05);
      exp_at(8, 8'hFF, 8'hFF, "consec_released");
      tick(10);

      key(1'b1, 1'b0, 8'h03);
      exp_at(4, 8'hFF, 8'hFF, "skip_early");
      exp_at(5, 8'hBF, 8'hFF, "skip");
      tick(8);
      key(1'b0, 1'b0, 8'h03);
      tick(8);

      key(1'b1, 1'b0, 8'h04);
      coin_window(4, 20, 8'hEF, "coin2_hold");
      tick(100);
      key(1'b0, 1'b0, 8'h04);
      tick(8);

      key(1'b1, 1'b0, 8'h04);
      coin_window(4, 30, 8'hEF, "coin2_repress_gap");
      tick(3);
      key(1'b0, 1'b0, 8'h04);
      tick(7);
      key(1'b1, 1'b0, 8'h04);
      tick(20);
      key(1'b0, 1'b0, 8'h04);
      tick(8);
      key(1'b1, 1'b0, 8'h04);
      coin_window(4, 20, 8'hEF, "coin2_second");
      tick(22);
      key(1'b0, 1'b0, 8'h04);
      tick(8);

      key(1'b1, 1'b0, 8'h04);
      exp_at(6, 8'hEF, 8'hFF, "coin_before_abort");
      exp_at(8, 8'hFF, 8'hFF, "coin_reset_abort");
      tick(7);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) exp_at(k, 8'hFF, 8'hFF, "after_abort");
      tick(8);
      key(1'b0, 1'b0, 8'h04);
      tick(8);

      key(1'b1, 1'b0, 8'h2E);
`ifdef PACMAN_INPUTS_JPAC_EN
      coin_window(4, 14, 8'hDF, "jpac_coin1");
`else
      coin_window(4, 14, 8'hFF, "jpac_coin1_ignored");
`endif
      tick(16);
      key(1'b0, 1'b0, 8'h2E);
      tick(8);

      for (int i = 0; i < 300 && due_q.size() > 0; i++) tick(1);
      nchk++;
      assert (due_q.size() == 0) npass++;
      else begin
         nfail++;
         $error("FAIL drain pending=%0d expected 0", due_q.size());
      end
      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end
endmodule
